// File: rtl/mc_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_alu_pkg
// Description : Shared constants for the multi-cycle ALU: opcode encoding,
//               FSM state encoding and a helper that classifies opcodes
//               handled by the iterative datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_alu_pkg;

  // Opcode encoding; 10..15 are illegal.
  localparam logic [3:0] c_op_add  = 4'd0;
  localparam logic [3:0] c_op_sub  = 4'd1;
  localparam logic [3:0] c_op_and  = 4'd2;
  localparam logic [3:0] c_op_or   = 4'd3;
  localparam logic [3:0] c_op_slt  = 4'd4;
  localparam logic [3:0] c_op_sltu = 4'd5;
  localparam logic [3:0] c_op_xor  = 4'd6;
  localparam logic [3:0] c_op_mul  = 4'd7;
  localparam logic [3:0] c_op_divu = 4'd8;
  localparam logic [3:0] c_op_remu = 4'd9;

  // Control FSM state encoding.
  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_calc = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  // True for opcodes executed bit-serially by mc_alu_iter.
  function automatic logic op_is_iter(input logic [3:0] op);
    return (op == c_op_mul) || (op == c_op_divu) || (op == c_op_remu);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_alu_if.sv
`default_nettype none
// ============================================================================
// Module      : mc_alu_if
// Description : Operation/result handshake bundle of the multi-cycle ALU.
//               Request side : in_valid, in_ready, opcode, in1, in2
//               Response side: out_valid, out_ready, result, zero,
//                              negative, illegal
//               slave  = ALU view, master = requester/consumer view.
// Revision    : 1.0 - initial release
// ============================================================================
interface mc_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             negative;
  logic             illegal;

  modport slave (
    input  in_valid, opcode, in1, in2, out_ready,
    output in_ready, out_valid, result, zero, negative, illegal
  );

  modport master (
    output in_valid, opcode, in1, in2, out_ready,
    input  in_ready, out_valid, result, zero, negative, illegal
  );
endinterface
`default_nettype wire

// File: rtl/mc_alu_iter.sv
`default_nettype none
// ============================================================================
// Module      : mc_alu_iter
// Description : Bit-serial multiply (shift-add) and unsigned divide /
//               remainder (restoring shift-subtract). One bit per cycle,
//               WIDTH cycles after the start edge.
// Ports       : clk, rst_n      - clock, async active-low reset
//               i_start         - capture i_op/i_a/i_b and begin
//               i_op            - c_op_mul / c_op_divu / c_op_remu
//               i_a, i_b        - operands (multiplicand/dividend, multiplier/divisor)
//               o_done          - the current cycle performs the final step
//               o_res           - value produced by the current step (final when o_done)
// Revision    : 1.0 - initial release
// ============================================================================
module mc_alu_iter
  import mc_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_res
);

  localparam int               c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

  logic               r_busy;
  logic [c_cnt_w-1:0] r_cnt;
  logic [3:0]         r_op;
  logic [WIDTH-1:0]   r_acc;  // product accumulator / partial remainder
  logic [WIDTH-1:0]   r_opa;  // shifting multiplicand / dividend->quotient
  logic [WIDTH-1:0]   r_opb;  // shifting multiplier / divisor

  logic [WIDTH-1:0]   w_mul_acc;
  logic [WIDTH:0]     w_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_quo_next;

  assign w_mul_acc  = r_acc + (r_opb[0] ? r_opa : '0);

  // Restoring step: bring the next dividend bit into the remainder and
  // subtract the divisor if it fits. A zero divisor always "fits", which
  // yields an all-ones quotient and leaves the dividend as remainder.
  assign w_shift    = {r_acc, r_opa[WIDTH-1]};
  assign w_ge       = (w_shift >= {1'b0, r_opb});
  assign w_rem_next = w_ge ? WIDTH'(w_shift - {1'b0, r_opb}) : w_shift[WIDTH-1:0];
  assign w_quo_next = {r_opa[WIDTH-2:0], w_ge};

  assign o_done = r_busy && (r_cnt == c_last);
  assign o_res  = (r_op == c_op_mul)  ? w_mul_acc  :
                  (r_op == c_op_divu) ? w_quo_next : w_rem_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_op   <= '0;
      r_acc  <= '0;
      r_opa  <= '0;
      r_opb  <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_op   <= i_op;
      r_acc  <= '0;
      r_opa  <= i_a;
      r_opb  <= i_b;
    end else if (r_busy) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_op == c_op_mul) begin
        r_acc <= w_mul_acc;
        r_opa <= r_opa << 1;
        r_opb <= r_opb >> 1;
      end else begin
        r_acc <= w_rem_next;
        r_opa <= w_quo_next;
      end
      if (o_done) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mc_alu.sv
`default_nettype none
// ============================================================================
// Module      : mc_alu
// Description : Multi-cycle ALU with valid/ready handshakes. Single-cycle
//               ops complete on the accepting edge; Mul/Divu/Remu run
//               WIDTH more cycles in mc_alu_iter. Results are held until
//               the consumer takes them.
// Ports       : clk   - clock
//               rst_n - asynchronous active-low reset
//               bus   - mc_alu_if.slave (operation request + result response)
// Revision    : 1.0 - initial release
// ============================================================================
module mc_alu
  import mc_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  mc_alu_if.slave   bus
);

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [WIDTH-1:0] r_result;
  logic             r_illegal;

  logic             w_accept;
  logic             w_is_iter;
  logic             w_is_illegal;
  logic             w_slt;
  logic             w_sltu;
  logic [WIDTH-1:0] w_comb_res;
  logic             w_iter_done;
  logic [WIDTH-1:0] w_iter_res;

  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_is_iter    = op_is_iter(bus.opcode);
  assign w_is_illegal = (bus.opcode > c_op_remu);
  assign w_slt        = ($signed(bus.in1) < $signed(bus.in2));
  assign w_sltu       = (bus.in1 < bus.in2);

  always_comb begin
    w_comb_res = '0;  // also the result for illegal opcodes
    case (bus.opcode)
      c_op_add:  w_comb_res = bus.in1 + bus.in2;
      c_op_sub:  w_comb_res = bus.in1 - bus.in2;
      c_op_and:  w_comb_res = bus.in1 & bus.in2;
      c_op_or:   w_comb_res = bus.in1 | bus.in2;
      c_op_slt:  w_comb_res = {{(WIDTH-1){1'b0}}, w_slt};
      c_op_sltu: w_comb_res = {{(WIDTH-1){1'b0}}, w_sltu};
      c_op_xor:  w_comb_res = bus.in1 ^ bus.in2;
      default:   w_comb_res = '0;
    endcase
  end

  mc_alu_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_accept && w_is_iter),
    .i_op    (bus.opcode),
    .i_a     (bus.in1),
    .i_b     (bus.in2),
    .o_done  (w_iter_done),
    .o_res   (w_iter_res)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic. DONE always returns to IDLE, so a new operation can
  // never be taken on the edge that completes an output transfer.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle: if (w_accept)      w_next_state = w_is_iter ? c_st_calc : c_st_done;
      c_st_calc: if (w_iter_done)   w_next_state = c_st_done;
      c_st_done: if (bus.out_ready) w_next_state = c_st_idle;
      default:                      w_next_state = c_st_idle;
    endcase
  end

  // Output logic
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (r_state)
      c_st_idle: bus.in_ready  = 1'b1;
      c_st_done: bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  // Result capture: single-cycle ops on acceptance, iterative ops on the
  // final step. Nothing changes while DONE, so the result stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result  <= '0;
      r_illegal <= 1'b0;
    end else if ((r_state == c_st_idle) && w_accept && !w_is_iter) begin
      r_result  <= w_comb_res;
      r_illegal <= w_is_illegal;
    end else if ((r_state == c_st_calc) && w_iter_done) begin
      r_result  <= w_iter_res;
      r_illegal <= 1'b0;
    end
  end

  assign bus.result   = r_result;
  assign bus.zero     = (r_result == '0);
  assign bus.negative = r_result[WIDTH-1];
  assign bus.illegal  = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_mc_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_alu
// Description : Directed self-checking bench for mc_alu (WIDTH = 32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_alu;
  import mc_alu_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  mc_alu_if #(.WIDTH(32)) bus ();

  mc_alu #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one operation, measure latency in edges (accepting edge = 1),
  // check the held result, then take it with out_ready.
  task automatic run_op(input string tag, input logic [3:0] opc,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_ill,
                        input int exp_lat);
    int   lat;
    logic rdy_seen;
    @(negedge clk);
    chk($sformatf("%s.in_ready_idle", tag), bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.opcode   = opc;
    bus.in1      = a;
    bus.in2      = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in1      = $urandom;
    bus.in2      = $urandom;
    bus.opcode   = 4'($urandom_range(0, 15));
    lat      = 1;
    rdy_seen = 1'b0;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      rdy_seen = rdy_seen | bus.in_ready;
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("%s.latency", tag), 64'(lat), 64'(exp_lat));
    chk($sformatf("%s.result", tag), bus.result, exp_res);
    chk($sformatf("%s.illegal", tag), bus.illegal, exp_ill);
    chk($sformatf("%s.zero", tag), bus.zero, (exp_res == 32'd0));
    chk($sformatf("%s.negative", tag), bus.negative, exp_res[31]);
    chk($sformatf("%s.busy_ready", tag), rdy_seen | bus.in_ready, 0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk($sformatf("%s.released", tag), bus.out_valid, 0);
    chk($sformatf("%s.back_idle", tag), bus.in_ready, 1);
  endtask

  initial begin
    logic stale;
    total = 0;
    bad   = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.opcode    = 4'd0;
    bus.in1       = '0;
    bus.in2       = '0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst.out_valid", bus.out_valid, 0);
    chk("rst.result", bus.result, 0);
    chk("rst.zero", bus.zero, 1);
    chk("rst.negative", bus.negative, 0);
    chk("rst.illegal", bus.illegal, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst.in_ready", bus.in_ready, 1);

    // Single-cycle ops
    run_op("sub",     c_op_sub,  32'd5,          32'd7,          32'hFFFF_FFFE, 1'b0, 1);
    run_op("add_wrap",c_op_add,  32'hFFFF_FFFF,  32'd1,          32'h0000_0000, 1'b0, 1);
    run_op("and",     c_op_and,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000, 1'b0, 1);
    run_op("or",      c_op_or,   32'hF0F0_F0F0,  32'hFF00_FF00,  32'hFFF0_FFF0, 1'b0, 1);
    run_op("xor",     c_op_xor,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0FF0_0FF0, 1'b0, 1);
    run_op("slt",     c_op_slt,  32'h8000_0000,  32'd1,          32'd1,         1'b0, 1);
    run_op("sltu",    c_op_sltu, 32'h8000_0000,  32'd1,          32'd0,         1'b0, 1);
    run_op("illegal", 4'd12,     32'd3,          32'd4,          32'd0,         1'b1, 1);

    // Iterative ops
    run_op("mul",     c_op_mul,  32'h0001_0001,  32'h0001_0001,  32'h0002_0001, 1'b0, 33);
    run_op("mul_ones",c_op_mul,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001, 1'b0, 33);
    run_op("divu",    c_op_divu, 32'd100,        32'd7,          32'd14,        1'b0, 33);
    run_op("remu",    c_op_remu, 32'd100,        32'd7,          32'd2,         1'b0, 33);
    run_op("divu0",   c_op_divu, 32'd9,          32'd0,          32'hFFFF_FFFF, 1'b0, 33);
    run_op("remu0",   c_op_remu, 32'd9,          32'd0,          32'd9,         1'b0, 33);

    // Hold with out_ready low, then check no bypass on the releasing edge
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.opcode   = c_op_add;
    bus.in1      = 32'd10;
    bus.in2      = 32'd20;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("hold.valid0", bus.out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("hold.result%0d", i), bus.result, 32'd30);
      chk($sformatf("hold.valid%0d", i + 1), bus.out_valid, 1);
      chk($sformatf("hold.in_ready%0d", i), bus.in_ready, 0);
    end
    bus.in_valid  = 1'b1;
    bus.opcode    = c_op_or;
    bus.in1       = 32'h0000_000F;
    bus.in2       = 32'h0000_00F0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("nobypass.out_valid", bus.out_valid, 0);
    chk("nobypass.in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("nobypass.next_valid", bus.out_valid, 1);
    chk("nobypass.next_result", bus.result, 32'h0000_00FF);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;

    // Reset in the middle of a Divu; previous result (0xFF) must be cleared
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.opcode   = c_op_divu;
    bus.in1      = 32'd100;
    bus.in2      = 32'd7;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("midrst.calc_busy", bus.in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", bus.out_valid, 0);
    chk("midrst.result", bus.result, 0);
    chk("midrst.zero", bus.zero, 1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;  // ignored while nothing is held
    stale = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      stale = stale | bus.out_valid;
    end
    bus.out_ready = 1'b0;
    chk("midrst.no_stale", stale, 0);
    run_op("post_rst_add", c_op_add, 32'd1, 32'd2, 32'd3, 1'b0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
